coin_spawn_controller: RTL
==========================

COIN_SPAWN_CONTROLLER -- requirements
Module: coin_spawn_controller

Interface
REQ-001 SHALL have parameter GAP_FRAMES, default 60, frame ticks between coin clear and next spawn (legal 1..255).
REQ-002 SHALL have parameter TRAVEL_FRAMES, default 120, frame ticks a coin stays active before it counts as missed (legal 1..255).
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, LFSR reset value (nonzero).
REQ-004 SHALL have ports: i_clk  in  1  single system clock; all logic on rising edge.
REQ-005 SHALL have: i_rst  in  1  synchronous active-high reset.
REQ-006 SHALL have: i_v_sync  in  1  asynchronous frame strobe, synchronised internally.
REQ-007 SHALL have: i_game_run  in  1  high enables spawning.
REQ-008 SHALL have: i_penguin_hit  in  1  level from coin generator; coin collected.
REQ-009 SHALL have: o_active  out  2  lane code to coin generator: 00 none, 01 left, 10 mid, 11 right.
REQ-010 SHALL have: o_spawn_pulse  out  1  one-cycle pulse per spawn.
REQ-011 SHALL have: o_coins  out  12  collected-coin count.
REQ-012 SHALL have: o_misses  out  8  missed-coin count.

Function
REQ-013 SHALL pass i_v_sync through a 2-flop synchroniser plus edge register; frame tick = one-cycle pulse on synchronised rising edge, 3 cycles after input edge.
REQ-014 SHALL implement FSM states IDLE, GAP, SPAWN, ACTIVE, CLEAR; o_active registered, nonzero only in ACTIVE.
REQ-015 IDLE: o_active=00; i_game_run=1 -> GAP with frame counter cleared.
REQ-016 GAP: counter increments per frame tick; tick with counter==GAP_FRAMES-1 -> SPAWN.
REQ-017 SPAWN: lasts exactly one cycle; latches lane; asserts o_spawn_pulse; -> ACTIVE with counter cleared; o_active shows latched lane from the next cycle.
REQ-018 ACTIVE: i_penguin_hit=1 -> o_coins+1, -> CLEAR; else tick with counter==TRAVEL_FRAMES-1 -> o_misses+1, -> CLEAR.
REQ-019 Hit and timeout in same cycle: hit wins; only o_coins increments.
REQ-020 CLEAR: o_active=00; -> GAP only after at least one frame tick seen in CLEAR AND i_penguin_hit=0, so downstream sees an idle frame and drops its hit flag.
REQ-021 i_game_run=0 in any state -> IDLE next cycle, o_active=00; counts retained; a coin aborted this way is neither hit nor miss.
REQ-022 o_coins SHALL saturate at 4095; o_misses SHALL saturate at 255; no wrap.
REQ-023 Frame counter 8 bits, cleared on every state entry; never wraps within legal parameters.
REQ-024 i_penguin_hit ignored outside ACTIVE.

Reset
REQ-025 i_rst=1 at a clock edge: state IDLE, o_active=00, o_spawn_pulse=0, o_coins=0, o_misses=0, frame counter 0, synchroniser flops 0, LFSR=LFSR_SEED, round-robin pointer=01.
REQ-026 Reset mid-ACTIVE SHALL drop o_active to 00 the following cycle with no count change beyond clearing.

Configuration
REQ-027 Macro COIN_SPAWN_LFSR_EN defined: 16-bit Galois LFSR (taps 16,14,13,11) advances every cycle while not in reset; lane = lfsr[1:0], with 00 mapped to 10.
REQ-028 Macro undefined: no LFSR; lane follows round-robin 01,10,11,01,... advancing once per spawn; LFSR_SEED unused.

Verification
REQ-029 GAP_FRAMES=2, TRAVEL_FRAMES=3, macro undefined, run=1, no hits -> lanes 01,10,11,01 in order; each ACTIVE lasts 3 ticks; o_misses=4, o_coins=0.
REQ-030 Hit asserted 1 tick into ACTIVE and held 2 ticks -> o_coins=1; o_active=00 until hit low and one tick elapses; then 2-tick gap before next spawn.
REQ-031 Hit asserted on same cycle as timeout tick -> o_coins+1, o_misses unchanged.
REQ-032 Preload o_coins to 4095 via 4095 hits, one more hit -> o_coins stays 4095.
REQ-033 Reset pulsed mid-ACTIVE -> next cycle o_active=00, all counts 0, state IDLE; with macro defined, first lane after reset matches golden LFSR from 16'hACE1 for fixed cycle count.
REQ-034 i_game_run dropped mid-ACTIVE -> o_active=00 next cycle, counts unchanged; raised again -> full GAP before next spawn.

Source files
------------

// File: rtl/coin_spawn_controller.sv
// coin_spawn_controller
//   Spawns one coin at a time into one of three lanes. Timing comes from
//   frame ticks derived from the asynchronous v_sync strobe. A spawned coin
//   stays active until it is collected (penguin hit) or until it has been on
//   screen for TRAVEL_FRAMES ticks (a miss). After that comes a clear phase and
//   then a gap of GAP_FRAMES ticks before the next coin.
//
// Build option:
//   COIN_SPAWN_LFSR_EN  defined   : lane is picked by a 16-bit Galois LFSR
//                       undefined : lane is picked round-robin 01,10,11,...
//
// Ports:
//   i_clk          in   1   system clock, rising edge
//   i_rst          in   1   synchronous active-high reset
//   i_v_sync       in   1   asynchronous frame strobe
//   i_game_run     in   1   high enables spawning
//   i_penguin_hit  in   1   coin collected (level from coin generator)
//   o_active       out  2   lane of the live coin: 00 none, 01 L, 10 M, 11 R
//   o_spawn_pulse  out  1   one-cycle pulse per spawn
//   o_coins        out  12  collected coins, saturating at 4095
//   o_misses       out  8   missed coins, saturating at 255
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | game stopped, no coin
// GAP    | counting frame ticks before the next spawn
// SPAWN  | single cycle: pick a lane, pulse o_spawn_pulse
// ACTIVE | coin on screen, waiting for a hit or the travel timeout
// CLEAR  | coin gone; wait for a frame tick with the hit level low

module coin_spawn_controller #(
  parameter int          GAP_FRAMES    = 60,
  parameter int          TRAVEL_FRAMES = 120,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_v_sync,
  input  logic        i_game_run,
  input  logic        i_penguin_hit,
  output logic [1:0]  o_active,
  output logic        o_spawn_pulse,
  output logic [11:0] o_coins,
  output logic [7:0]  o_misses
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GAP    = 3'd1,
    ST_SPAWN  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_CLEAR  = 3'd4
  } state_t;

  localparam logic [7:0] GAP_LAST    = 8'(GAP_FRAMES - 1);
  localparam logic [7:0] TRAVEL_LAST = 8'(TRAVEL_FRAMES - 1);

  state_t      state;
  state_t      state_nxt;
  logic        vs_meta;
  logic        vs_sync;
  logic        vs_prev;
  logic        frame_tick;
  logic [7:0]  frame_cnt;
  logic        clear_tick_seen;
  logic        coin_hit;
  logic        coin_miss;
  logic [1:0]  new_lane;
  logic [1:0]  active_d;

  // ---------------------------------------------------------------------
  // v_sync synchroniser and rising-edge detect
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= i_v_sync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign frame_tick = vs_sync & ~vs_prev;

  // ---------------------------------------------------------------------
  // Lane source
  // ---------------------------------------------------------------------
`ifdef COIN_SPAWN_LFSR_EN
  logic [15:0] lfsr;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Lane 00 would mean "no coin", so fold it onto the middle lane
  assign new_lane = (lfsr[1:0] == 2'b00) ? 2'b10 : lfsr[1:0];
`else
  logic [1:0] rr_ptr;
  logic       unused_seed;

  assign unused_seed = ^LFSR_SEED;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr <= 2'b01;
    end else if (state == ST_SPAWN) begin
      rr_ptr <= (rr_ptr == 2'b11) ? 2'b01 : rr_ptr + 2'd1;
    end
  end

  assign new_lane = rr_ptr;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (!i_game_run) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: state_nxt = ST_GAP;
        ST_GAP: begin
          if (frame_tick && frame_cnt == GAP_LAST) state_nxt = ST_SPAWN;
        end
        ST_SPAWN: state_nxt = ST_ACTIVE;
        ST_ACTIVE: begin
          if (i_penguin_hit) begin
            state_nxt = ST_CLEAR;
          end else if (frame_tick && frame_cnt == TRAVEL_LAST) begin
            state_nxt = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          // Hold off until downstream has had a whole idle frame to drop its hit flag
          if ((clear_tick_seen || frame_tick) && !i_penguin_hit) state_nxt = ST_GAP;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs and datapath controls
  // ---------------------------------------------------------------------
  always_comb begin
    o_spawn_pulse = (state == ST_SPAWN);
    coin_hit      = i_game_run && (state == ST_ACTIVE) && i_penguin_hit;
    coin_miss     = i_game_run && (state == ST_ACTIVE) && !i_penguin_hit &&
                    frame_tick && (frame_cnt == TRAVEL_LAST);
    active_d      = 2'b00;
    if (state_nxt == ST_ACTIVE) begin
      active_d = (state == ST_SPAWN) ? new_lane : o_active;
    end
  end

  // ---------------------------------------------------------------------
  // Frame counter, clear-phase tick flag, lane register, score counters
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt       <= 8'd0;
      clear_tick_seen <= 1'b0;
      o_active        <= 2'b00;
      o_coins         <= 12'd0;
      o_misses        <= 8'd0;
    end else begin
      o_active <= active_d;

      if (state_nxt != state) begin
        frame_cnt <= 8'd0;
      end else if (frame_tick && (state == ST_GAP || state == ST_ACTIVE)) begin
        frame_cnt <= frame_cnt + 8'd1;
      end

      if (state != ST_CLEAR || state_nxt != ST_CLEAR) begin
        clear_tick_seen <= 1'b0;
      end else if (frame_tick) begin
        clear_tick_seen <= 1'b1;
      end

      if (coin_hit && o_coins != 12'hFFF) begin
        o_coins <= o_coins + 12'd1;
      end
      if (coin_miss && o_misses != 8'hFF) begin
        o_misses <= o_misses + 8'd1;
      end
    end
  end

endmodule
